// File: rtl/shift_load_arbiter.sv
// shift_load_arbiter: shares one WIDTH x SIZE shift register between requesters A and B, one burst at a time.
// Define FIXED_PRIORITY_EN so that IDLE ties always go to A; otherwise ties are broken round-robin.
module shift_load_arbiter #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 8,
    localparam int CW   = $clog2(SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_window,
    input  logic             consume,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             shift_signal,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    fill_count,
    output logic             full,
    output logic [1:0]       owner
);
    typedef enum logic [1:0] {S_IDLE, S_OWN_A, S_OWN_B, S_FULL} state_t;

    localparam logic [CW-1:0] FULL_CNT = CW'(SIZE);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_fill, w_fill_nxt;
    logic             r_shift;
    logic [WIDTH-1:0] r_data;
    logic             w_room, w_acc_a, w_acc_b, w_acc, w_last_word, w_rel, w_grant_a;

    assign w_room      = r_fill < FULL_CNT;
    assign a_ready     = rst_n & (r_state == S_OWN_A) & load_window & ~consume & w_room;
    assign b_ready     = rst_n & (r_state == S_OWN_B) & load_window & ~consume & w_room;
    assign w_acc_a     = a_valid & a_ready;
    assign w_acc_b     = b_valid & b_ready;
    assign w_acc       = w_acc_a | w_acc_b;
    assign w_last_word = w_acc & (r_fill == FULL_CNT - 1'b1);
    // Owner gives up the register on its final word, or when it goes idle inside an open window.
    assign w_rel = ~consume & load_window &
                   (((r_state == S_OWN_A) & (w_last_word | ~a_valid)) |
                    ((r_state == S_OWN_B) & (w_last_word | ~b_valid)));

`ifdef FIXED_PRIORITY_EN
    assign w_grant_a = a_valid;
`else
    logic r_last_b;
    assign w_grant_a = a_valid & (~b_valid | r_last_b);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_last_b <= 1'b1;
        else if (w_rel)
            r_last_b <= (r_state == S_OWN_B);
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = consume ? '0 : r_fill + CW'(w_acc);
        if (consume)
            w_state_nxt = S_IDLE;
        else begin
            case (r_state)
                S_IDLE:
                    if (r_fill == FULL_CNT)
                        w_state_nxt = S_FULL;
                    else if (a_valid | b_valid)
                        w_state_nxt = w_grant_a ? S_OWN_A : S_OWN_B;
                S_OWN_A, S_OWN_B:
                    if (w_rel)
                        w_state_nxt = w_last_word ? S_FULL : S_IDLE;
                default:
                    w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_fill  <= '0;
            r_shift <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            r_shift <= w_acc;
            r_data  <= w_acc_a ? a_data : (w_acc_b ? b_data : r_data);
        end
    end

    assign shift_signal = r_shift;
    assign data_out     = r_data;
    assign fill_count   = r_fill;
    assign full         = r_fill == FULL_CNT;
    assign owner        = {r_state == S_OWN_B, r_state == S_OWN_A};
endmodule

// File: tb/tb_shift_load_arbiter.sv
// tb_shift_load_arbiter: directed bench; accepted words go into a scoreboard queue and are matched against shift pulses.
module tb_shift_load_arbiter;
    logic       clk = 0, rst_n = 0, load_window = 0, consume = 0;
    logic       a_valid = 0, b_valid = 0;
    logic [7:0] a_data = 0, b_data = 0;
    logic       a_ready, b_ready, shift_signal, full;
    logic [7:0] data_out;
    logic [3:0] fill_count;
    logic [1:0] owner;
    int         checks = 0, errors = 0, pulses = 0, p0;
    logic [7:0] sb[$];
    logic [1:0] exp_second_owner;

    always #5 clk = ~clk;

    shift_load_arbiter #(.WIDTH(8), .SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n), .load_window(load_window), .consume(consume),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .shift_signal(shift_signal), .data_out(data_out),
        .fill_count(fill_count), .full(full), .owner(owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic accept(input bit is_b, input logic [7:0] d, input logic [3:0] f_after);
        if (is_b) begin
            b_data = d;
            #1 chk("b_ready", b_ready, 1);
        end else begin
            a_data = d;
            #1 chk("a_ready", a_ready, 1);
        end
        sb.push_back(d);
        tick;
        chk("fill_count", fill_count, f_after);
    endtask

    always @(negedge clk) begin
        if (shift_signal === 1'b1) begin
            pulses++;
            if (sb.size() == 0)
                chk("unexpected_pulse", 1, 0);
            else
                chk("data_out", data_out, sb.pop_front());
        end
    end

    initial begin
`ifdef FIXED_PRIORITY_EN
        exp_second_owner = 2'b01;
`else
        exp_second_owner = 2'b10;
`endif
        // Reset, then a full A burst
        a_valid = 1;
        tick;
        tick;
        chk("rst_shift", shift_signal, 0);
        chk("rst_data", data_out, 0);
        chk("rst_fill", fill_count, 0);
        chk("rst_full", full, 0);
        chk("rst_owner", owner, 0);
        chk("rst_a_ready", a_ready, 0);
        rst_n = 1;
        load_window = 1;
        tick;
        chk("t1_owner", owner, 1);
        chk("t1_fill0", fill_count, 0);
        chk("t1_no_shift", shift_signal, 0);
        for (int i = 0; i < 8; i++) accept(0, 8'h10 + 8'(i), 4'(i + 1));
        chk("t1_full", full, 1);
        chk("t1_owner_full", owner, 0);
        #1 chk("t1_a_ready_full", a_ready, 0);
        consume = 1;
        tick;
        consume = 0;
        chk("t1_cons_fill", fill_count, 0);
        chk("t1_cons_full", full, 0);
        chk("t1_pulses", pulses, 8);

        // Tie arbitration: first A, then the other side (A again when fixed)
        rst_n = 0;
        a_valid = 0;
        tick;
        rst_n = 1;
        a_valid = 1;
        b_valid = 1;
        b_data = 8'hb0;
        tick;
        chk("t2_first_owner", owner, 1);
        for (int i = 0; i < 8; i++) accept(0, 8'h60 + 8'(i), 4'(i + 1));
        chk("t2_full", full, 1);
        consume = 1;
        tick;
        consume = 0;
        tick;
        chk("t2_second_owner", owner, exp_second_owner);
        consume = 1;
        #1 chk("t2_cons_a_ready", a_ready, 0);
        chk("t2_cons_b_ready", b_ready, 0);
        tick;
        consume = 0;
        a_valid = 0;
        b_valid = 0;
        chk("t2_owner_none", owner, 0);
        chk("t2_fill", fill_count, 0);

        // A abandons after 3 words, B completes the fill
        p0 = pulses;
        a_valid = 1;
        tick;
        chk("t3_owner_a", owner, 1);
        b_valid = 1;
        for (int i = 0; i < 3; i++) accept(0, 8'h20 + 8'(i), 4'(i + 1));
        a_valid = 0;
        #1 chk("t3_ready_no_valid", a_ready, 1);
        tick;
        chk("t3_owner_rel", owner, 0);
        chk("t3_fill_kept", fill_count, 3);
        tick;
        chk("t3_owner_b", owner, 2);
        for (int i = 0; i < 5; i++) accept(1, 8'h30 + 8'(i), 4'(i + 4));
        chk("t3_full", full, 1);
        chk("t3_owner_full", owner, 0);
        tick;
        chk("t3_pulses", pulses - p0, 8);
        consume = 1;
        b_valid = 0;
        tick;
        consume = 0;

        // Window closes during an A burst; release is not evaluated while closed
        a_valid = 1;
        tick;
        chk("t4_owner", owner, 1);
        accept(0, 8'h40, 1);
        load_window = 0;
        #1 chk("t4_ready_closed", a_ready, 0);
        tick;
        chk("t4_fill_hold", fill_count, 1);
        chk("t4_owner_hold", owner, 1);
        a_valid = 0;
        tick;
        chk("t4_fill_hold2", fill_count, 1);
        chk("t4_owner_hold2", owner, 1);
        a_valid = 1;
        load_window = 1;
        accept(0, 8'h41, 2);

        // consume collides with a presented word at fill_count 4
        accept(0, 8'h42, 3);
        accept(0, 8'h43, 4);
        consume = 1;
        a_data = 8'h44;
        #1 chk("t5_ready_consume", a_ready, 0);
        tick;
        consume = 0;
        chk("t5_fill", fill_count, 0);
        chk("t5_owner", owner, 0);
        chk("t5_full", full, 0);

        // Reset one cycle after an accept
        tick;
        chk("t6_owner", owner, 1);
        accept(0, 8'h50, 1);
        rst_n = 0;
        a_data = 8'h51;
        #1 chk("t6_ready_rst", a_ready, 0);
        tick;
        chk("t6_shift", shift_signal, 0);
        chk("t6_data", data_out, 0);
        chk("t6_fill", fill_count, 0);
        chk("t6_owner", owner, 0);
        chk("t6_full", full, 0);
        rst_n = 1;
        a_valid = 0;
        tick;
        tick;
        chk("sb_empty", sb.size(), 0);
        chk("total_pulses", pulses, 29);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
